logicalstep_button_pio: RTL and testbench
=========================================

// Module: logicalstep_button_pio
// PURPOSE
//  Avalon-MM slave input PIO for LogicalStep push-buttons/switches; input-side counterpart of the LED output PIO.
//  Synchronises and debounces in_port per bit, exposes debounced level, latches edges into edge-capture register.
//  Raises a level IRQ to the Nios II when any unmasked captured edge is pending. Sits on the system interconnect.
// PARAMETERS
//  WIDTH            4      number of input bits (1..32)
//  DEBOUNCE_CYCLES  50000  consecutive stable clk cycles required to accept a new level (>=1; 1 ms @ 50 MHz)
//  EDGE_TYPE        1      0 = rising, 1 = falling, 2 = any edge captured
//  CNT_W            16     debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      Avalon word address
//  chipselect  in   1      Avalon slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  readdata    out  32     read data, zero-wait-state (combinational from address)
//  irq         out  1      level interrupt request
//  in_port     in   WIDTH  raw asynchronous button/switch inputs
// BEHAVIOUR
//  Reset: sync flops, debounced level, previous level, counters, irq_mask, edge_capture all 0; irq = 0; readdata = 0.
//  Sync: 2-flop synchroniser per bit -> sync_q.
//  Debounce per bit: if sync_q == stable: cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync_q, cnt <= 0;
//   else cnt <= cnt+1. Pulse shorter than DEBOUNCE_CYCLES in sync_q -> no change to stable.
//  Latency: in_port step (held) -> stable changes DEBOUNCE_CYCLES+2 clk edges after first sampling edge.
//  Edge detect: stable_d <= stable each cycle; rise = stable & ~stable_d; fall = ~stable & stable_d;
//   selected per EDGE_TYPE. edge_capture bit set the cycle after stable changes (stable_d lag).
//  Inputs held high through reset produce a rising edge on first acceptance (stable reset is 0) - defined behaviour.
//  Register map (addr): 0 DATA RO = stable zero-extended; 1 DIRECTION RO = 0; 2 IRQMASK RW bits[WIDTH-1:0];
//   3 EDGECAPTURE: read = edge_capture; write = 1-to-clear per bit (writedata bit 1 clears that bit).
//  Write accepted when chipselect && !write_n; writes to 0/1 ignored. Bits above WIDTH read 0, writes ignored.
//  Reads: no side effects; readdata = mux(address) regardless of chipselect.
//  Simultaneous new edge and clear on same bit in same cycle: set wins (bit stays 1). Clear of other bits unaffected.
//  irq = |(edge_capture & irq_mask), combinational from registers; mask change takes effect same cycle it is written
//   (next clk edge). Masked edges still captured; unmasking a pending bit asserts irq immediately after write.
//  Async reset mid-debounce: counter and stable return to 0 at once; no partial edge retained.
// STRUCTURE
//  Shared package logicalstep_pio_pkg: ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
//   EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
//  Sub-module pio_debounce_bit (synchroniser + counter + stable, params DEBOUNCE_CYCLES/CNT_W), instantiated
//   WIDTH times via generate; top holds edge detect, registers, read mux, irq.
// TESTING (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless stated)
//  1 Reset: reset_n=0 with in_port=4'hF -> readdata=0, irq=0; release -> DATA reads 4'hF after 6 clk edges, EDGECAP=0.
//  2 Debounce: in_port[0] 1->0 glitch 3 cycles then back -> DATA[0] stays 1, EDGECAP=0; held low 6+ cycles ->
//   DATA[0]=0 at edge 6, EDGECAP=4'h1 next cycle.
//  3 IRQ: IRQMASK=0 then falling on bit2 -> EDGECAP=4'h4, irq=0; write IRQMASK=4'h4 -> irq=1 cycle after write.
//  4 Clear: EDGECAP=4'h5, write addr3 data 4'h1 -> EDGECAP=4'h4, irq follows mask; write 4'hF -> 0, irq=0.
//  5 Collision: bit1 edge_capture set in same cycle as write-1-to-clear bit1 -> bit1 reads 1 afterwards.
//  6 EDGE_TYPE=2: bit3 0->1->0 with 10-cycle holds -> edge_capture[3] set twice; DIRECTION reads 0; writes to addr0 ignored.

Source files
------------

// File: rtl/logicalstep_pio_pkg.sv
// Shared constants for the LogicalStep Avalon-MM PIO blocks: register map
// and edge-capture selection codes.
package logicalstep_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_sel_rise(input int edge_type);
    return (edge_type == EDGE_RISING) || (edge_type == EDGE_ANY);
  endfunction

  function automatic logic edge_sel_fall(input int edge_type);
    return (edge_type == EDGE_FALLING) || (edge_type == EDGE_ANY);
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive agreeing samples.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_stable
);
  import logicalstep_pio_pkg::*;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Any sample agreeing with the accepted level restarts the count, so a
  // glitch shorter than DEBOUNCE_CYCLES never reaches the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM_CNT) begin
      r_stable <= r_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/logicalstep_button_pio.sv
// Avalon-MM input PIO for LogicalStep buttons/switches: debounced level,
// edge-capture with write-1-to-clear, maskable level interrupt.
module logicalstep_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);
  import logicalstep_pio_pkg::*;

  localparam logic SEL_RISE = edge_sel_rise(EDGE_TYPE);
  localparam logic SEL_FALL = edge_sel_fall(EDGE_TYPE);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;
  logic             w_unused_wdata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (in_port[gi]),
      .o_stable(w_stable[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stable_d <= '0;
    else          r_stable_d <= w_stable;
  end

  assign w_rise = w_stable & ~r_stable_d;
  assign w_fall = ~w_stable & r_stable_d;
  assign w_edge = (w_rise & {WIDTH{SEL_RISE}}) | (w_fall & {WIDTH{SEL_FALL}});

  assign w_wr           = chipselect && !write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = |writedata;
  assign w_clr          = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
    end else if (w_wr && address == ADDR_IRQMASK) begin
      r_irq_mask <= w_wdata;
    end
  end

  // Set has priority over clear so an edge arriving during a clear is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edge_cap <= '0;
    else          r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(w_stable);
      ADDR_DIR:     readdata = '0;
      ADDR_IRQMASK: readdata = 32'(r_irq_mask);
      ADDR_EDGECAP: readdata = 32'(r_edge_cap);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_logicalstep_button_pio.sv
// Directed bench for logicalstep_button_pio: falling-edge instance plus an
// any-edge instance, short debounce so each scenario fits in a few cycles.
module tb_logicalstep_button_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  in_port;
  logic [31:0] readdata2;
  logic        irq2;
  logic [3:0]  in_port2;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] d;

  logicalstep_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .in_port(in_port)
  );

  logicalstep_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2), .irq(irq2),
    .in_port(in_port2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  task automatic rd2(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata2;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset_n = 1'b0; in_port = 4'hF; in_port2 = 4'h0;
    tick(3);
    rd(2'd0, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp %h", v, 32'h0); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq); end
    reset_n = 1'b1;
    tick(5);
    rd(2'd0, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_data_edge5 got %h exp %h", v, 32'h0); end
    tick(1);
    rd(2'd0, v); n_vec++;
    if (v !== 32'hF) begin n_err++; $display("FAIL reset_data_edge6 got %h exp %h", v, 32'hF); end
    tick(1);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_edgecap got %h exp %h", v, 32'h0); end
  endtask

  task automatic test_debounce;
    logic [31:0] v;
    in_port = 4'hE;
    tick(3);
    in_port = 4'hF;
    tick(8);
    rd(2'd0, v); n_vec++;
    if (v !== 32'hF) begin n_err++; $display("FAIL glitch_data got %h exp %h", v, 32'hF); end
    rd(2'd3, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL glitch_edgecap got %h exp %h", v, 32'h0); end
    in_port = 4'hE;
    tick(5);
    rd(2'd0, v); n_vec++;
    if (v !== 32'hF) begin n_err++; $display("FAIL hold_data_edge5 got %h exp %h", v, 32'hF); end
    tick(1);
    rd(2'd0, v); n_vec++;
    if (v !== 32'hE) begin n_err++; $display("FAIL hold_data_edge6 got %h exp %h", v, 32'hE); end
    rd(2'd3, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL hold_edgecap_edge6 got %h exp %h", v, 32'h0); end
    tick(1);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL hold_edgecap_edge7 got %h exp %h", v, 32'h1); end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    wr(2'd3, 32'hF);
    in_port = 4'hA;
    tick(10);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h4) begin n_err++; $display("FAIL irq_edgecap got %h exp %h", v, 32'h4); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked got %b exp 0", irq); end
    address = 2'd2; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    #1; n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_before_write got %b exp 0", irq); end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    #1; n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_after_unmask got %b exp 1", irq); end
    rd(2'd2, v); n_vec++;
    if (v !== 32'h4) begin n_err++; $display("FAIL irqmask_read got %h exp %h", v, 32'h4); end
  endtask

  task automatic test_clear;
    logic [31:0] v;
    in_port = 4'hB;
    tick(10);
    in_port = 4'hA;
    tick(10);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h5) begin n_err++; $display("FAIL clear_pre got %h exp %h", v, 32'h5); end
    wr(2'd3, 32'h1);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h4) begin n_err++; $display("FAIL clear_bit0 got %h exp %h", v, 32'h4); end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL clear_irq_mask4 got %b exp 1", irq); end
    wr(2'd2, 32'h1);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL clear_irq_mask1 got %b exp 0", irq); end
    wr(2'd2, 32'h4);
    wr(2'd3, 32'hF);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL clear_all got %h exp %h", v, 32'h0); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL clear_all_irq got %b exp 0", irq); end
  endtask

  task automatic test_collision;
    logic [31:0] v;
    in_port = 4'h8;
    tick(6);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL collide_pre got %h exp %h", v, 32'h0); end
    wr(2'd3, 32'h2);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h2) begin n_err++; $display("FAIL collide_set_wins got %h exp %h", v, 32'h2); end
    wr(2'd3, 32'h2);
    rd(2'd3, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL collide_later_clear got %h exp %h", v, 32'h0); end
  endtask

  task automatic test_any_edge;
    logic [31:0] v;
    in_port2 = 4'h8;
    tick(10);
    rd2(2'd3, v); n_vec++;
    if (v !== 32'h8) begin n_err++; $display("FAIL any_rise_cap got %h exp %h", v, 32'h8); end
    rd2(2'd0, v); n_vec++;
    if (v !== 32'h8) begin n_err++; $display("FAIL any_rise_data got %h exp %h", v, 32'h8); end
    wr(2'd3, 32'h8);
    rd2(2'd3, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL any_cleared got %h exp %h", v, 32'h0); end
    in_port2 = 4'h0;
    tick(10);
    rd2(2'd3, v); n_vec++;
    if (v !== 32'h8) begin n_err++; $display("FAIL any_fall_cap got %h exp %h", v, 32'h8); end
    n_vec++;
    if (irq2 !== 1'b0) begin n_err++; $display("FAIL any_irq_masked got %b exp 0", irq2); end
    rd2(2'd1, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL any_direction got %h exp %h", v, 32'h0); end
    rd(2'd1, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL direction got %h exp %h", v, 32'h0); end
    wr(2'd0, 32'hF);
    rd2(2'd0, v); n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL any_data_wr_ignored got %h exp %h", v, 32'h0); end
    rd(2'd0, v); n_vec++;
    if (v !== 32'h8) begin n_err++; $display("FAIL data_wr_ignored got %h exp %h", v, 32'h8); end
  endtask

  initial begin
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    reset_n = 1'b0; in_port = 4'hF; in_port2 = 4'h0;
    @(negedge clk);
    test_reset;
    test_debounce;
    test_irq;
    test_clear;
    test_collision;
    test_any_edge;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
